// File: rtl/sram_stream_arbiter_if.sv
// Bus bundle for sram_stream_arbiter: AHB-lite subordinate port plus the read-only stream request port.
// The arbiter connects through the slave modport. The requester side uses the master modport.
interface sram_stream_arbiter_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 32,
  parameter int DEPTH  = 2048
);
  localparam int W_SRAM_ADDR = $clog2(DEPTH);

  logic                   ahbls_hready_resp;
  logic                   ahbls_hready;
  logic                   ahbls_hresp;
  logic [W_ADDR-1:0]      ahbls_haddr;
  logic                   ahbls_hwrite;
  logic [1:0]             ahbls_htrans;
  logic [2:0]             ahbls_hsize;
  logic [W_DATA-1:0]      ahbls_hwdata;
  logic [W_DATA-1:0]      ahbls_hrdata;

  logic                   strm_req_vld;
  logic                   strm_req_rdy;
  logic [W_SRAM_ADDR-1:0] strm_req_addr;
  logic                   strm_rsp_vld;
  logic [W_DATA-1:0]      strm_rsp_data;

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hwdata,
    input  strm_req_vld, strm_req_addr,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    output strm_req_rdy, strm_rsp_vld, strm_rsp_data
  );

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hwdata,
    output strm_req_vld, strm_req_addr,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    input  strm_req_rdy, strm_rsp_vld, strm_rsp_data
  );
endinterface

// File: rtl/sram_stream_arbiter.sv
// Arbitrates one single-port synchronous SRAM between an AHB-lite subordinate and a stream read port.
// The stream has default priority. After MAX_RUN consecutive stream wins, a pending AHB access is served.
module sram_stream_arbiter #(
  parameter int W_DATA  = 32,
  parameter int W_ADDR  = 32,
  parameter int DEPTH   = 2048,
  parameter int MAX_RUN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sram_stream_arbiter_if.slave       bus,
  output logic                       sram_cs_n,
  output logic                       sram_we_n,
  output logic [W_DATA/8-1:0]        sram_be_n,
  output logic [$clog2(DEPTH)-1:0]   sram_addr,
  output logic [W_DATA-1:0]          sram_wdata,
  input  logic [W_DATA-1:0]          sram_rdata
);
  // W_DATA must be at least 16 so that the byte-lane offset field is non-empty.
  localparam int W_STRB      = W_DATA / 8;
  localparam int W_BYTEADDR  = $clog2(W_STRB);
  localparam int W_SRAM_ADDR = $clog2(DEPTH);
  localparam int W_RUN       = $clog2(MAX_RUN + 1);
  localparam logic [W_RUN-1:0] RUN_LIMIT = W_RUN'(MAX_RUN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [W_RUN-1:0]       r_run_cnt;
  logic [W_RUN-1:0]       w_run_cnt_nxt;
  logic                   r_strm_rsp_vld;
  logic                   r_write;
  logic [W_SRAM_ADDR-1:0] r_row;
  logic [W_BYTEADDR-1:0]  r_align;
  logic [2:0]             r_size;

  logic                   w_aphase;
  logic                   w_capture;
  logic                   w_ahb_cand;
  logic                   w_strm_gnt;
  logic                   w_ahb_gnt;
  logic                   w_ahb_wr_gnt;
  logic                   w_hready_resp;
  logic [W_STRB-1:0]      w_be;
  logic                   w_unused;

  assign w_aphase   = bus.ahbls_htrans[1] && bus.ahbls_hready;
  assign w_ahb_cand = (r_state == S_WAIT);

  // Grants are gated by rst_n so the SRAM sees no access while reset is held.
  assign w_strm_gnt   = rst_n && bus.strm_req_vld && (!w_ahb_cand || (r_run_cnt < RUN_LIMIT));
  assign w_ahb_gnt    = rst_n && w_ahb_cand && !w_strm_gnt;
  assign w_ahb_wr_gnt = w_ahb_gnt && r_write;

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_hready_resp = 1'b1;
    w_state_nxt   = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_aphase) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_hready_resp = w_ahb_wr_gnt;
        if (w_ahb_gnt) begin
          if (!r_write)      w_state_nxt = S_RDATA;
          else if (w_aphase) w_state_nxt = S_WAIT;
          else               w_state_nxt = S_IDLE;
        end
      end
      S_RDATA: begin
        w_state_nxt = w_aphase ? S_WAIT : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A new address phase is only accepted on a cycle that completes the previous data phase.
  assign w_capture = w_aphase && w_hready_resp;

  always_comb begin
    w_run_cnt_nxt = '0;
    if (w_ahb_cand && !w_ahb_gnt) begin
      w_run_cnt_nxt = (w_strm_gnt && (r_run_cnt < RUN_LIMIT)) ? r_run_cnt + 1'b1 : r_run_cnt;
    end
  end

  // Byte lanes [align, align + 2^size) are written; lanes past the word edge are dropped.
  always_comb begin
    w_be = '0;
    for (int i = 0; i < W_STRB; i++) begin
      w_be[i] = (i >= int'(r_align)) && (i < int'(r_align) + int'(32'd1 << r_size));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_run_cnt      <= '0;
      r_strm_rsp_vld <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_run_cnt      <= w_run_cnt_nxt;
      r_strm_rsp_vld <= w_strm_gnt;
    end
  end

  // NOTE: the captured address-phase fields are pure datapath and are qualified by r_state, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_write <= bus.ahbls_hwrite;
      r_row   <= bus.ahbls_haddr[W_BYTEADDR +: W_SRAM_ADDR];
      r_align <= bus.ahbls_haddr[W_BYTEADDR-1:0];
      r_size  <= bus.ahbls_hsize;
    end
  end

  assign sram_cs_n  = !(w_strm_gnt || w_ahb_gnt);
  assign sram_we_n  = !w_ahb_wr_gnt;
  assign sram_be_n  = w_ahb_wr_gnt ? ~w_be : '1;
  assign sram_addr  = w_ahb_gnt ? r_row : bus.strm_req_addr;
  assign sram_wdata = bus.ahbls_hwdata;

  assign bus.ahbls_hready_resp = w_hready_resp;
  assign bus.ahbls_hresp       = 1'b0;
  assign bus.ahbls_hrdata      = sram_rdata;
  assign bus.strm_req_rdy      = w_strm_gnt;
  assign bus.strm_rsp_vld      = r_strm_rsp_vld;
  assign bus.strm_rsp_data     = sram_rdata;

  assign w_unused = ^{bus.ahbls_haddr[W_ADDR-1:W_BYTEADDR+W_SRAM_ADDR], bus.ahbls_htrans[0]};
endmodule

// File: tb/tb_sram_stream_arbiter.sv
// Directed bench for sram_stream_arbiter: byte-lane write table plus hand-written
// sequences for read latency, stream latency, run-length fairness, back-to-back and reset.
module tb_sram_stream_arbiter;
  localparam int W_DATA  = 32;
  localparam int W_ADDR  = 32;
  localparam int DEPTH   = 2048;
  localparam int MAX_RUN = 4;

  logic        clk;
  logic        rst_n;
  logic        sram_cs_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] mem [0:DEPTH-1];

  int n_checks = 0;
  int n_errors = 0;

  sram_stream_arbiter_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .DEPTH(DEPTH)) bus ();

  sram_stream_arbiter #(
    .W_DATA(W_DATA), .W_ADDR(W_ADDR), .DEPTH(DEPTH), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_cs_n  (sram_cs_n),
    .sram_we_n  (sram_we_n),
    .sram_be_n  (sram_be_n),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Single AHB subordinate on the bus: hready loops back from hready_resp.
  assign bus.ahbls_hready = bus.ahbls_hready_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with byte enables and 1-cycle read latency.
  always @(posedge clk) begin
    if (!sram_cs_n) begin
      if (!sram_we_n) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [3:0]  exp_be_n;
    logic [10:0] exp_row;
    logic [31:0] exp_word;
  } wr_vec_t;

  wr_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ahb_idle();
    bus.ahbls_htrans = 2'b00;
    bus.ahbls_hwrite = 1'b0;
  endtask

  task automatic ahb_aphase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
    bus.ahbls_htrans = 2'b10;
    bus.ahbls_haddr  = addr;
    bus.ahbls_hwrite = wr;
    bus.ahbls_hsize  = size;
  endtask

  // Uncontended word read of haddr 0x40 (row 0x10): one wait state, then data.
  task automatic read_row10(input string tag);
    @(negedge clk); ahb_aphase(32'h40, 1'b0, 3'd2);
    @(negedge clk); ahb_idle(); #1;
    check({tag, "_rd_cs_n"},   sram_cs_n, 0);
    check({tag, "_rd_addr"},   sram_addr, 32'h10);
    check({tag, "_rd_hready"}, bus.ahbls_hready_resp, 0);
    @(negedge clk); #1;
    check({tag, "_rd_hready2"}, bus.ahbls_hready_resp, 1);
    check({tag, "_rd_hrdata"},  bus.ahbls_hrdata, 32'h12345678);
  endtask

  initial begin
    vecs[0] = '{32'h003, 3'd0, 32'hAABBCCDD, 4'b0111, 11'h000, 32'hAA000000};
    vecs[1] = '{32'h104, 3'd2, 32'h11223344, 4'b0000, 11'h041, 32'h11223344};
    vecs[2] = '{32'h202, 3'd1, 32'h55667788, 4'b0011, 11'h080, 32'h55660000};
    vecs[3] = '{32'h301, 3'd0, 32'h99AABBCC, 4'b1101, 11'h0C0, 32'h0000BB00};
    vecs[4] = '{32'h400, 3'd1, 32'h12345678, 4'b1100, 11'h100, 32'h00005678};

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[11'h010] = 32'h12345678;
    mem[11'h123] = 32'hCAFEF00D;
    sram_rdata = 32'h0;

    // Reset state, with a stream request already pending to show it is held off.
    rst_n = 1'b0;
    ahb_idle();
    bus.ahbls_haddr   = 32'h0;
    bus.ahbls_hsize   = 3'd2;
    bus.ahbls_hwdata  = 32'h0;
    bus.strm_req_vld  = 1'b1;
    bus.strm_req_addr = 11'h123;
    #1;
    check("rst_hready",  bus.ahbls_hready_resp, 1);
    check("rst_rsp_vld", bus.strm_rsp_vld, 0);
    check("rst_rdy",     bus.strm_req_rdy, 0);
    check("rst_cs_n",    sram_cs_n, 1);
    check("rst_we_n",    sram_we_n, 1);
    check("rst_be_n",    sram_be_n, 4'hF);
    check("rst_hresp",   bus.ahbls_hresp, 0);
    @(negedge clk);
    bus.strm_req_vld = 1'b0;
    rst_n = 1'b1;

    // Write vectors: byte-lane strobes in the first data-phase cycle, then read back.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ahb_aphase(vecs[i].haddr, 1'b1, vecs[i].hsize); #1;
      check("wr_ap_hready", bus.ahbls_hready_resp, 1);
      @(negedge clk); ahb_idle(); bus.ahbls_hwdata = vecs[i].hwdata; #1;
      check("wr_cs_n",   sram_cs_n, 0);
      check("wr_we_n",   sram_we_n, 0);
      check("wr_be_n",   sram_be_n, vecs[i].exp_be_n);
      check("wr_addr",   sram_addr, vecs[i].exp_row);
      check("wr_hready", bus.ahbls_hready_resp, 1);
      @(negedge clk); ahb_aphase(32'(vecs[i].exp_row) << 2, 1'b0, 3'd2);
      @(negedge clk); ahb_idle(); #1;
      check("rb_hready", bus.ahbls_hready_resp, 0);
      check("rb_we_n",   sram_we_n, 1);
      check("rb_be_n",   sram_be_n, 4'hF);
      @(negedge clk); #1;
      check("rb_hready2", bus.ahbls_hready_resp, 1);
      check("rb_data",    bus.ahbls_hrdata, vecs[i].exp_word);
    end

    read_row10("plain");

    // BUSY transfer in IDLE: no state change, no SRAM access afterwards.
    @(negedge clk); bus.ahbls_htrans = 2'b01; bus.ahbls_haddr = 32'h40; #1;
    check("busy_hready", bus.ahbls_hready_resp, 1);
    check("busy_cs_n",   sram_cs_n, 1);
    @(negedge clk); ahb_idle(); #1;
    check("busy_next_hready", bus.ahbls_hready_resp, 1);
    check("busy_next_cs_n",   sram_cs_n, 1);

    // Single stream request: response valid on the next cycle only.
    @(negedge clk); bus.strm_req_vld = 1'b1; bus.strm_req_addr = 11'h123; #1;
    check("st_rdy",     bus.strm_req_rdy, 1);
    check("st_cs_n",    sram_cs_n, 0);
    check("st_we_n",    sram_we_n, 1);
    check("st_addr",    sram_addr, 32'h123);
    check("st_rsp_vld0", bus.strm_rsp_vld, 0);
    @(negedge clk); bus.strm_req_vld = 1'b0; #1;
    check("st_rsp_vld1", bus.strm_rsp_vld, 1);
    check("st_rsp_data", bus.strm_rsp_data, 32'hCAFEF00D);
    check("st_rdy_low",  bus.strm_req_rdy, 0);
    @(negedge clk); #1;
    check("st_rsp_vld2", bus.strm_rsp_vld, 0);

    // Run-length limit: stream held high, AHB read served after MAX_RUN stream wins.
    @(negedge clk); bus.strm_req_vld = 1'b1; ahb_aphase(32'h40, 1'b0, 3'd2); #1;
    check("run_ap_rdy",    bus.strm_req_rdy, 1);
    check("run_ap_hready", bus.ahbls_hready_resp, 1);
    for (int k = 1; k <= MAX_RUN; k++) begin
      @(negedge clk); ahb_idle(); #1;
      check("run_strm_rdy",    bus.strm_req_rdy, 1);
      check("run_strm_hready", bus.ahbls_hready_resp, 0);
      check("run_strm_addr",   sram_addr, 32'h123);
    end
    @(negedge clk); #1;
    check("run_ahb_rdy",     bus.strm_req_rdy, 0);
    check("run_ahb_cs_n",    sram_cs_n, 0);
    check("run_ahb_addr",    sram_addr, 32'h10);
    check("run_ahb_hready",  bus.ahbls_hready_resp, 0);
    check("run_ahb_rsp_vld", bus.strm_rsp_vld, 1);
    @(negedge clk); #1;
    check("run_rd_hready",  bus.ahbls_hready_resp, 1);
    check("run_rd_hrdata",  bus.ahbls_hrdata, 32'h12345678);
    check("run_rd_rdy",     bus.strm_req_rdy, 1);
    check("run_rd_rsp_vld", bus.strm_rsp_vld, 0);
    @(negedge clk); bus.strm_req_vld = 1'b0; #1;
    check("run_end_rsp_vld",  bus.strm_rsp_vld, 1);
    check("run_end_rsp_data", bus.strm_rsp_data, 32'hCAFEF00D);

    // Back-to-back write then read of 0x80 (row 0x20).
    @(negedge clk); ahb_aphase(32'h80, 1'b1, 3'd2);
    @(negedge clk); bus.ahbls_hwdata = 32'hDEADBEEF; ahb_aphase(32'h80, 1'b0, 3'd2); #1;
    check("b2b_wr_hready", bus.ahbls_hready_resp, 1);
    check("b2b_wr_we_n",   sram_we_n, 0);
    check("b2b_wr_addr",   sram_addr, 32'h20);
    check("b2b_wr_be_n",   sram_be_n, 4'h0);
    @(negedge clk); ahb_idle(); #1;
    check("b2b_rd_hready", bus.ahbls_hready_resp, 0);
    check("b2b_rd_cs_n",   sram_cs_n, 0);
    check("b2b_rd_we_n",   sram_we_n, 1);
    check("b2b_rd_addr",   sram_addr, 32'h20);
    @(negedge clk); #1;
    check("b2b_rd_hready2", bus.ahbls_hready_resp, 1);
    check("b2b_rd_hrdata",  bus.ahbls_hrdata, 32'hDEADBEEF);

    // Reset while an AHB read waits behind an active stream.
    @(negedge clk); bus.strm_req_vld = 1'b1; bus.strm_req_addr = 11'h123; ahb_aphase(32'h40, 1'b0, 3'd2);
    @(negedge clk); ahb_idle(); #1;
    check("mr_wait_hready", bus.ahbls_hready_resp, 0);
    check("mr_wait_rdy",    bus.strm_req_rdy, 1);
    #1 rst_n = 1'b0; #1;
    check("mr_cs_n",    sram_cs_n, 1);
    check("mr_we_n",    sram_we_n, 1);
    check("mr_be_n",    sram_be_n, 4'hF);
    check("mr_rdy",     bus.strm_req_rdy, 0);
    check("mr_hready",  bus.ahbls_hready_resp, 1);
    check("mr_rsp_vld", bus.strm_rsp_vld, 0);
    @(negedge clk); bus.strm_req_vld = 1'b0; rst_n = 1'b1; #1;
    check("mr_rel_cs_n",   sram_cs_n, 1);
    check("mr_rel_hready", bus.ahbls_hready_resp, 1);
    read_row10("post_rst");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
